// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: three-master to one-slave Wishbone arbiter for the shared
// memory macro. M0 = instruction fetch (read-only), M1 = CPU data, M2 = DMA/debug.
// Round-robin by default, fixed priority M1 > M0 > M2 when FIXED_PRIO = 1.
// Optional watchdog (define WB_ARB_TIMEOUT_EN) aborts a stalled slave
// cycle with an error pulse and adds the timeout_o port.
module wb_mem_arbiter #(
   parameter int unsigned FIXED_PRIO     = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   // M0: instruction bus (read-only)
   input  logic [31:0] m0_adr_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   // M1: data bus
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   // M2: DMA / debug
   input  logic [31:0] m2_adr_i,
   input  logic [31:0] m2_dat_i,
   input  logic        m2_we_i,
   input  logic [3:0]  m2_sel_i,
   input  logic        m2_cyc_i,
   input  logic        m2_stb_i,
   output logic [31:0] m2_dat_o,
   output logic        m2_ack_o,
   output logic        m2_err_o,
   // slave side
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   // arbitration status
   output logic [2:0]  grant_o,
   output logic [1:0]  last_grant_o
`ifdef WB_ARB_TIMEOUT_EN
   ,
   output logic        timeout_o
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   logic [2:0] req;
   logic [1:0] win_idx;
   logic       cur_cyc;
   logic       abort;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_mem_arbiter: TIMEOUT_CYCLES must be in 2..65535");
   end

   // request vector, granted master's cyc, and winner selection
   always_comb begin
      req     = {m2_cyc_i & m2_stb_i, m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
      cur_cyc = |(grant_o & {m2_cyc_i, m1_cyc_i, m0_cyc_i});
      win_idx = last_grant_o;
      if (FIXED_PRIO != 0) begin
         if (req[1])      win_idx = 2'd1;
         else if (req[0]) win_idx = 2'd0;
         else             win_idx = 2'd2;
      end else begin
         case (last_grant_o)
            2'd0: begin
               if (req[1])      win_idx = 2'd1;
               else if (req[2]) win_idx = 2'd2;
               else             win_idx = 2'd0;
            end
            2'd1: begin
               if (req[2])      win_idx = 2'd2;
               else if (req[0]) win_idx = 2'd0;
               else             win_idx = 2'd1;
            end
            default: begin
               if (req[0])      win_idx = 2'd0;
               else if (req[1]) win_idx = 2'd1;
               else             win_idx = 2'd2;
            end
         endcase
      end
   end

   // arbitration FSM: grant on any request, hold while granted cyc stays high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant_o      <= '0;
         last_grant_o <= 2'd2;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  grant_o      <= 3'(3'b001 << win_idx);
                  last_grant_o <= win_idx;
                  state        <= BUSY;
               end
            end
            BUSY: begin
               if (!cur_cyc) begin
                  grant_o <= '0;
                  state   <= IDLE;
               end
            end
            default: begin
               grant_o <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] wd_cnt;

   assign abort     = (state == BUSY) && (wd_cnt == 16'(TIMEOUT_CYCLES));
   assign timeout_o = abort;

   // watchdog: counts strobed cycles without a slave response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if ((state == IDLE && |req) || abort || s_ack_i || s_err_i) begin
         wd_cnt <= '0;
      end else if (s_stb_o) begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   // slave-side mux driven straight from the grant register
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      case (grant_o)
         3'b001: begin
            s_adr_o = m0_adr_i;
            s_sel_o = '1;
            s_cyc_o = m0_cyc_i & ~abort;
            s_stb_o = m0_stb_i & ~abort;
         end
         3'b010: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_cyc_o = m1_cyc_i & ~abort;
            s_stb_o = m1_stb_i & ~abort;
         end
         3'b100: begin
            s_adr_o = m2_adr_i;
            s_dat_o = m2_dat_i;
            s_we_o  = m2_we_i;
            s_sel_o = m2_sel_i;
            s_cyc_o = m2_cyc_i & ~abort;
            s_stb_o = m2_stb_i & ~abort;
         end
         default: ;
      endcase
   end

   // response routing: only the granted master sees data/ack/err
   always_comb begin
      m0_dat_o = grant_o[0] ? s_dat_i : '0;
      m1_dat_o = grant_o[1] ? s_dat_i : '0;
      m2_dat_o = grant_o[2] ? s_dat_i : '0;
      m0_ack_o = grant_o[0] & s_ack_i & ~abort;
      m1_ack_o = grant_o[1] & s_ack_i & ~abort;
      m2_ack_o = grant_o[2] & s_ack_i & ~abort;
      m0_err_o = grant_o[0] & (s_err_i | abort);
      m1_err_o = grant_o[1] & (s_err_i | abort);
      m2_err_o = grant_o[2] & (s_err_i | abort);
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Testbench for wb_mem_arbiter: instance 0 round-robin, instance 1 fixed priority.
// Covers the timeout path when WB_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] adr[3], wdat[3];
   logic        we[3], cyc[3], stb[3];
   logic [3:0]  sel[3];
   logic [31:0] s_rdat;
   logic        s_ack, s_err;

   logic [31:0] mdat[2][3];
   logic        mack[2][3], merr[2][3];
   logic [31:0] sadr[2], sdat[2];
   logic        swe[2], scyc[2], sstb[2], tmo[2];
   logic [3:0]  ssel[2];
   logic [2:0]  gnt[2];
   logic [1:0]  lst[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      wb_mem_arbiter #(.FIXED_PRIO(g), .TIMEOUT_CYCLES(TO)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .m0_adr_i(adr[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]),
         .m0_dat_o(mdat[g][0]), .m0_ack_o(mack[g][0]), .m0_err_o(merr[g][0]),
         .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
         .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]),
         .m1_dat_o(mdat[g][1]), .m1_ack_o(mack[g][1]), .m1_err_o(merr[g][1]),
         .m2_adr_i(adr[2]), .m2_dat_i(wdat[2]), .m2_we_i(we[2]), .m2_sel_i(sel[2]),
         .m2_cyc_i(cyc[2]), .m2_stb_i(stb[2]),
         .m2_dat_o(mdat[g][2]), .m2_ack_o(mack[g][2]), .m2_err_o(merr[g][2]),
         .s_adr_o(sadr[g]), .s_dat_o(sdat[g]), .s_we_o(swe[g]), .s_sel_o(ssel[g]),
         .s_cyc_o(scyc[g]), .s_stb_o(sstb[g]),
         .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
         .grant_o(gnt[g]), .last_grant_o(lst[g])
`ifdef WB_ARB_TIMEOUT_EN
         , .timeout_o(tmo[g])
`endif
      );
`ifndef WB_ARB_TIMEOUT_EN
      assign tmo[g] = 1'b0;
`endif
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // own: index of the master holding the bus (-1 = none); ptr: last winner
   int own[2], ptr[2], cnt[2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         own[i] = -1; ptr[i] = 2; cnt[i] = 0;
      end
   endtask

   function automatic logic timed_out(input int i);
`ifdef WB_ARB_TIMEOUT_EN
      return (own[i] >= 0) && (cnt[i] == TO);
`else
      return 1'b0;
`endif
   endfunction

   task automatic calc(input int i, output logic [70:0] es, output logic [101:0] em,
                       output logic [5:0] ec);
      int o = own[i];
      logic t = timed_out(i);
      int base;
      es = '0;
      em = '0;
      ec = {3'b000, 2'(ptr[i]), t};
      if (o >= 0) begin
         es = {adr[o], (o == 0) ? 32'h0 : wdat[o], (o == 0) ? 1'b0 : we[o],
               (o == 0) ? 4'hF : sel[o], cyc[o] & ~t, stb[o] & ~t};
         base = (2 - o) * 34;
         em[base + 33 -: 32] = s_rdat;
         em[base + 1]        = s_ack & ~t;
         em[base]            = s_err | t;
         ec[5:3]             = 3'(1 << o);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int o = own[i];
         if (o < 0) begin
            int w = -1;
            if (i == 1) begin
               if (cyc[1] && stb[1])      w = 1;
               else if (cyc[0] && stb[0]) w = 0;
               else if (cyc[2] && stb[2]) w = 2;
            end else begin
               for (int k = 1; k <= 3; k++) begin
                  int idx = (ptr[i] + k) % 3;
                  if (w < 0 && cyc[idx] && stb[idx]) w = idx;
               end
            end
            if (w >= 0) begin
               own[i] = w; ptr[i] = w; cnt[i] = 0;
            end
         end else begin
            logic t = timed_out(i);
            if (t || s_ack || s_err) cnt[i] = 0;
            else if (stb[o]) cnt[i]++;
            if (!cyc[o]) own[i] = -1;
         end
      end
   endtask

   task automatic clear_inputs();
      for (int n = 0; n < 3; n++) begin
         adr[n] = '0; wdat[n] = '0; we[n] = 1'b0; sel[n] = '0; cyc[n] = 1'b0; stb[n] = 1'b0;
      end
      s_rdat = '0; s_ack = 1'b0; s_err = 1'b0;
   endtask

   task automatic do_reset();
      logic [70:0]  es;
      logic [101:0] em;
      logic [5:0]   ec;
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         calc(i, es, em, ec);
         chk("reset_state",
             {mdat[i][0], mack[i][0], merr[i][0], mdat[i][1], mack[i][1], merr[i][1],
              mdat[i][2], mack[i][2], merr[i][2], scyc[i], sstb[i], swe[i], ssel[i],
              gnt[i], lst[i], tmo[i]},
             {em, 7'b0, ec});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // table rows: {m2,m1,m0} request, slave ack, expected {grant,last,s_cyc,acks m2..m0}
   typedef struct packed {
      logic [2:0] req;
      logic       ack;
      logic [8:0] exp;
   } vec_t;
   vec_t tbl[11];

   initial begin
      logic [70:0]  es;
      logic [101:0] em;
      logic [5:0]   ec;
      int ack_div;

      tbl[0]  = '{3'b111, 1'b1, 9'b000_10_0_000};
      tbl[1]  = '{3'b111, 1'b1, 9'b001_00_1_001};
      tbl[2]  = '{3'b110, 1'b0, 9'b001_00_0_000};
      tbl[3]  = '{3'b110, 1'b0, 9'b000_00_0_000};
      tbl[4]  = '{3'b110, 1'b1, 9'b010_01_1_010};
      tbl[5]  = '{3'b100, 1'b0, 9'b010_01_0_000};
      tbl[6]  = '{3'b100, 1'b0, 9'b000_01_0_000};
      tbl[7]  = '{3'b100, 1'b1, 9'b100_10_1_100};
      tbl[8]  = '{3'b001, 1'b0, 9'b100_10_0_000};
      tbl[9]  = '{3'b001, 1'b0, 9'b000_10_0_000};
      tbl[10] = '{3'b001, 1'b1, 9'b001_00_1_001};

      clear_inputs();
      model_reset();

      // round-robin contention table
      do_reset();
      for (int r = 0; r < 11; r++) begin
         @(negedge clk);
         for (int n = 0; n < 3; n++) begin
            cyc[n] = tbl[r].req[n];
            stb[n] = tbl[r].req[n];
         end
         s_ack = tbl[r].ack;
         #1 chk($sformatf("rr_row%0d", r),
                {gnt[0], lst[0], scyc[0], mack[0][2], mack[0][1], mack[0][0]}, tbl[r].exp);
      end

      // single read by M0 with a two-cycle slave latency
      do_reset();
      @(negedge clk);
      adr[0] = 32'h100; cyc[0] = 1'b1; stb[0] = 1'b1;
      #1 chk("rd_arb_latency", {gnt[0], scyc[0]}, 4'b0000);
      @(negedge clk);
      #1 chk("rd_grant", {gnt[0], sstb[0], sadr[0], swe[0], ssel[0]},
             {3'b001, 1'b1, 32'h100, 1'b0, 4'hF});
      @(negedge clk);
      #1 chk("rd_wait", {mack[0][0], mack[0][1], mack[0][2]}, 3'b000);
      @(negedge clk);
      s_ack = 1'b1; s_rdat = 32'hDEADBEEF;
      #1 chk("rd_data", {mdat[0][0], mack[0][0], mack[0][1], mack[0][2], mdat[0][1]},
             {32'hDEADBEEF, 3'b100, 32'h0});

      // fixed priority: M1 beats M0, M0 only after M1 drops cyc
      do_reset();
      @(negedge clk);
      cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
      #1 chk("fp_latency", gnt[1], 3'b000);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk("fp_m1_held", gnt[1], 3'b010);
      end
      @(negedge clk);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      #1 chk("fp_m1_drop", gnt[1], 3'b010);
      @(negedge clk);
      #1 chk("fp_idle", gnt[1], 3'b000);
      @(negedge clk);
      #1 chk("fp_m0", gnt[1], 3'b001);

      // locked M1 write burst with stb gaps while M2 waits
      do_reset();
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'b0011;
      @(negedge clk);
      cyc[2] = 1'b1; stb[2] = 1'b1;
      #1 chk("burst_grant", gnt[0], 3'b010);
      for (int b = 0; b < 7; b++) begin
         @(negedge clk);
         stb[1] = (b % 2 == 0);
         s_ack = stb[1];
         wdat[1] = 32'(b);
         #1;
         if (stb[1])
            chk("burst_beat", {ssel[0], swe[0], sstb[0], gnt[0], mack[0][1], mack[0][2]},
                {4'b0011, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0});
         else
            chk("burst_gap", {gnt[0], mack[0][2], sstb[0]}, {3'b010, 1'b0, 1'b0});
      end
      @(negedge clk);
      cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0;
      #1 chk("burst_end", gnt[0], 3'b010);
      @(negedge clk);
      #1 chk("burst_idle", gnt[0], 3'b000);
      @(negedge clk);
      #1 chk("burst_m2", {gnt[0], scyc[0]}, {3'b100, 1'b1});

      // asynchronous reset in the middle of an M2 cycle
      do_reset();
      @(negedge clk);
      cyc[2] = 1'b1; stb[2] = 1'b1;
      @(negedge clk);
      #1 chk("mid_grant", {gnt[0], scyc[0]}, {3'b100, 1'b1});
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      #1 chk("mid_async_drop", {gnt[0], scyc[0], sstb[0], lst[0]}, {3'b000, 1'b0, 1'b0, 2'd2});
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("mid_idle", gnt[0], 3'b000);
      @(negedge clk);
      #1 chk("mid_m0_first", gnt[0], 3'b001);

`ifdef WB_ARB_TIMEOUT_EN
      // watchdog: slave never answers an M1 read
      do_reset();
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         #1 chk($sformatf("tmo_cycle%0d", k), {merr[0][1], tmo[0], sstb[0], mack[0][1]},
                (k == 9) ? 4'b1100 : 4'b0010);
      end
`endif

      // randomized traffic against the reference model, both instances
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         ack_div = (c < 2000) ? 3 : 9;
         @(negedge clk);
         for (int n = 0; n < 3; n++) begin
            if ($urandom_range(0, 11) == 0) cyc[n] = ~cyc[n];
            stb[n]  = cyc[n] && ($urandom_range(0, 3) != 0);
            adr[n]  = $urandom;
            wdat[n] = $urandom;
            we[n]   = 1'($urandom_range(0, 1));
            sel[n]  = 4'($urandom_range(0, 15));
         end
         s_ack  = ($urandom_range(0, ack_div - 1) == 0);
         s_err  = ($urandom_range(0, 19) == 0);
         s_rdat = $urandom;
         #1;
         for (int i = 0; i < 2; i++) begin
            calc(i, es, em, ec);
            chk($sformatf("rand_slave_i%0d", i),
                {sadr[i], sdat[i], swe[i], ssel[i], scyc[i], sstb[i]}, es);
            chk($sformatf("rand_master_i%0d", i),
                {mdat[i][0], mack[i][0], merr[i][0], mdat[i][1], mack[i][1], merr[i][1],
                 mdat[i][2], mack[i][2], merr[i][2]}, em);
            chk($sformatf("rand_ctrl_i%0d", i), {gnt[i], lst[i], tmo[i]}, ec);
         end
         @(posedge clk);
         model_step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
